dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter DataWidth, default 32, data path width (only 32 supported).
REQ-002 SHALL have parameter AddrWidth, default 15, core byte-address width.
REQ-003 SHALL have parameter AckTimeout, default 16, max cycles waited for mem_ack.
REQ-004 SHALL use one clock; reset asynchronous, active-low:
- brq_clk  in  1  clock.
- brq_rst  in  1  async reset, active-low.
REQ-005 SHALL have these core-side ports:
- core_addr  in  AddrWidth  byte address.
- core_wdata  in  32  store data, LSB-aligned.
- core_ren  in  1  load request.
- core_wen  in  1  store request.
- core_byte_en  in  3  func3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- core_rdata  out  32  extended load result.
- core_stall  out  1  hold-pipeline request.
- core_misalign  out  1  one-cycle misaligned/illegal-size flag.
- core_bus_err  out  1  one-cycle ack-timeout flag.
REQ-006 SHALL have these memory-side ports:
- mem_addr  out  AddrWidth-2  word address.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes.
- mem_req  out  1  request valid.
- mem_we  out  1  write qualifier.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_ack  in  1  completion, single cycle.

Function
REQ-007 SHALL implement FSM IDLE, REQ, DONE.
REQ-008 IDLE, (core_ren|core_wen) and the access is legal: latch addr, size, wdata, and direction (wen wins if both set); go to REQ. core_stall=1 combinationally this cycle.
REQ-009 Legal access: W with addr[1:0]==0; H/HU with addr[0]==0; B/BU with any address. Codes 011, 110, 111 are illegal.
REQ-010 IDLE with a request that is not legal: no memory access; state stays IDLE; core_misalign=1 on the next cycle; core_rdata=0; core_stall=0.
REQ-011 REQ: mem_req=1 and core_stall=1.
- mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_ack.
REQ-012 Strobes:
- B: 0001<<addr[1:0], byte replicated x4.
- H: addr[1] ? 1100 : 0011, halfword replicated x2.
- W: 1111.
- Loads: mem_wstrb=0000.
REQ-013 REQ with mem_ack=1: register formatted load data into core_rdata (stores leave it unchanged); go to DONE.
REQ-014 Load formatting: select lane by latched addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-015 Wait counter resets on entry to REQ and increments each cycle without ack.
- On reaching AckTimeout-1 without ack: mem_req drops; core_rdata=0; core_bus_err=1 for one cycle; go to DONE.
REQ-016 DONE lasts exactly one cycle: core_stall=0, mem_req=0, inputs ignored, then IDLE.
REQ-017 Latency with mem_ack on the first REQ cycle: request cycle, REQ, DONE = 3 cycles; result visible in DONE.
REQ-018 mem_ack while not in REQ SHALL be ignored.

Reset
REQ-019 On brq_rst=0, all of the following SHALL clear asynchronously:
- state=IDLE, counter=0.
- core_rdata=0, core_misalign=0, core_bus_err=0.
- mem_req=0, mem_we=0, mem_wstrb=0, mem_wdata=0, mem_addr=0.
REQ-020 Reset during REQ SHALL abandon the transfer with no flag raised.

Structure
REQ-021 Package brq_lsu_pkg SHALL hold the func3 size enum, the FSM state enum and the default AckTimeout constant.
REQ-022 Combinational sub-module brq_load_align SHALL do lane select and extension (REQ-014); everything else stays in dmem_bridge.

Verification
REQ-023 SB, addr 0x0006, wdata 0x000000A5, ack on 1st REQ cycle:
- mem_addr=0x0001, wstrb=0100, wdata=0xA5A5A5A5.
- stall high for 2 cycles.
REQ-024 LB, addr 0x0003, mem_rdata 0x80112233 -> core_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-025 LH, addr 0x0002, mem_rdata 0x7FFF0000 -> core_rdata=0x00007FFF; mem_wstrb=0000.
REQ-026 LW, addr 0x0002 -> core_misalign pulse, mem_req never asserted, stall low.
REQ-027 SW with no ack for 16 cycles:
- mem_req drops.
- core_bus_err pulses once.
- core_stall releases in DONE.
REQ-028 brq_rst asserted mid-REQ -> all outputs 0 immediately; after release, a following LW completes normally.

Source files
------------

// File: rtl/brq_lsu_pkg.sv
// Shared types and constants for the data-memory bridge: func3 size codes,
// bridge FSM states and the access-legality rule.
package brq_lsu_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ACK_TIMEOUT_DEFAULT = 16;

  // Codes 011, 110 and 111 fall through to illegal.
  function automatic logic f_legal(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      SZ_B, SZ_BU: f_legal = 1'b1;
      SZ_H, SZ_HU: f_legal = ~a[0];
      SZ_W:        f_legal = (a == 2'b00);
      default:     f_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/brq_load_align.sv
// Load formatter: picks the addressed byte/halfword lane from the memory word
// and sign- or zero-extends it according to the latched size code.
module brq_load_align
  import brq_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  size_e       i_size,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      SZ_B:    o_data = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_data = {24'd0, w_byte};
      SZ_H:    o_data = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Core-to-memory load/store bridge: legality check, strobe/lane generation,
// single outstanding request with ack timeout, and load result formatting.
module dmem_bridge
  import brq_lsu_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 15,
  parameter int AckTimeout = ACK_TIMEOUT_DEFAULT
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic [AddrWidth-1:0] core_addr,
  input  logic [DataWidth-1:0] core_wdata,
  input  logic                 core_ren,
  input  logic                 core_wen,
  input  logic [2:0]           core_byte_en,
  output logic [DataWidth-1:0] core_rdata,
  output logic                 core_stall,
  output logic                 core_misalign,
  output logic                 core_bus_err,
  output logic [AddrWidth-3:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [3:0]           mem_wstrb,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic [DataWidth-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam int CntW = $clog2(AckTimeout);
  localparam logic [CntW-1:0] CntLast = CntW'(AckTimeout - 1);

  function automatic logic [3:0] f_strb(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      SZ_B:    f_strb = 4'b0001 << a;
      SZ_H:    f_strb = a[1] ? 4'b1100 : 4'b0011;
      default: f_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] sz, input logic [31:0] d);
    case (sz)
      SZ_B:    f_wdata = {4{d[7:0]}};
      SZ_H:    f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  state_e                 r_state, w_next;
  logic [CntW-1:0]        r_cnt;
  logic [1:0]             r_lane;
  size_e                  r_size;
  logic [DataWidth-1:0]   r_rdata;
  logic                   r_misalign, r_bus_err, r_we;
  logic [AddrWidth-3:0]   r_addr;
  logic [DataWidth-1:0]   r_wdata;
  logic [3:0]             r_wstrb;
  logic [DataWidth-1:0]   w_load;
  logic                   w_req, w_legal, w_accept, w_reject, w_timeout, w_ack_ok;

  assign w_req     = core_ren | core_wen;
  assign w_legal   = f_legal(core_byte_en, core_addr[1:0]);
  assign w_accept  = (r_state == ST_IDLE) && w_req && w_legal;
  assign w_reject  = (r_state == ST_IDLE) && w_req && !w_legal;
  assign w_ack_ok  = (r_state == ST_REQ) && mem_ack;
  assign w_timeout = (r_state == ST_REQ) && !mem_ack && (r_cnt == CntLast);

  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    core_stall = 1'b0;
    mem_req    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        core_stall = w_accept;
        if (w_accept) w_next = ST_REQ;
      end
      ST_REQ: begin
        core_stall = 1'b1;
        mem_req    = 1'b1;
        if (mem_ack || w_timeout) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  brq_load_align u_align (
    .i_word (mem_rdata),
    .i_lane (r_lane),
    .i_size (r_size),
    .o_data (w_load)
  );

  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      r_cnt      <= '0;
      r_lane     <= 2'b00;
      r_size     <= SZ_B;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= 4'b0000;
    end else begin
      r_misalign <= w_reject;
      r_bus_err  <= w_timeout;
      if (w_accept) begin
        r_cnt   <= '0;
        r_lane  <= core_addr[1:0];
        r_size  <= size_e'(core_byte_en);
        r_we    <= core_wen;
        r_addr  <= core_addr[AddrWidth-1:2];
        r_wdata <= core_wen ? f_wdata(core_byte_en, core_wdata) : '0;
        r_wstrb <= core_wen ? f_strb(core_byte_en, core_addr[1:0]) : 4'b0000;
      end else if ((r_state == ST_REQ) && !mem_ack) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      // Stores leave the previous load result in place.
      if (w_ack_ok && !r_we)        r_rdata <= w_load;
      else if (w_timeout || w_reject) r_rdata <= '0;
    end
  end

  assign core_rdata    = r_rdata;
  assign core_misalign = r_misalign;
  assign core_bus_err  = r_bus_err;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_wstrb     = r_wstrb;
  assign mem_we        = r_we;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: stores, formatted loads, misalignment,
// ack timeout, stray acks and mid-transfer reset.
module tb_dmem_bridge;

  logic        brq_clk = 1'b0;
  logic        brq_rst;
  logic [14:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_ren, core_wen;
  logic [2:0]  core_byte_en;
  logic [31:0] core_rdata;
  logic        core_stall, core_misalign, core_bus_err;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req, mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_pass = 0;
  int n_total = 0;

  always #5 brq_clk = ~brq_clk;

  dmem_bridge dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ren(core_ren),
    .core_wen(core_wen), .core_byte_en(core_byte_en), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_misalign(core_misalign), .core_bus_err(core_bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic test_reset();
    brq_rst = 1'b0; core_addr = '0; core_wdata = '0; core_ren = 0; core_wen = 0;
    core_byte_en = 3'b010; mem_rdata = '0; mem_ack = 0;
    repeat (2) @(negedge brq_clk);
    n_total++; if ({core_rdata, core_misalign, core_bus_err} !== 34'd0) $display("FAIL reset_core act=%h exp=0", {core_rdata, core_misalign, core_bus_err}); else n_pass++;
    n_total++; if ({mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr, core_stall} !== 52'd0) $display("FAIL reset_mem act=%h exp=0", {mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr, core_stall}); else n_pass++;
    brq_rst = 1'b1;
    @(negedge brq_clk);
  endtask

  task automatic test_store_byte();
    core_addr = 15'h0006; core_wdata = 32'h000000A5; core_byte_en = 3'b000;
    core_wen = 1; core_ren = 1;
    #1;
    n_total++; if ({core_stall, mem_req} !== 2'b10) $display("FAIL sb_req_cycle act=%b exp=10", {core_stall, mem_req}); else n_pass++;
    @(negedge brq_clk);
    core_wen = 0; core_ren = 0;
    n_total++; if ({mem_req, mem_we, core_stall} !== 3'b111) $display("FAIL sb_req_ctl act=%b exp=111", {mem_req, mem_we, core_stall}); else n_pass++;
    n_total++; if (mem_addr !== 13'h0001) $display("FAIL sb_addr act=%h exp=0001", mem_addr); else n_pass++;
    n_total++; if (mem_wstrb !== 4'b0100) $display("FAIL sb_wstrb act=%b exp=0100", mem_wstrb); else n_pass++;
    n_total++; if (mem_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata act=%h exp=a5a5a5a5", mem_wdata); else n_pass++;
    mem_ack = 1;
    @(negedge brq_clk);
    mem_ack = 0;
    n_total++; if ({core_stall, mem_req, core_bus_err} !== 3'b000) $display("FAIL sb_done act=%b exp=000", {core_stall, mem_req, core_bus_err}); else n_pass++;
    @(negedge brq_clk);
  endtask

  task automatic test_loads();
    logic [14:0] t_addr [6] = '{15'h0003, 15'h0003, 15'h0002, 15'h0000, 15'h0002, 15'h0010};
    logic [2:0]  t_sz   [6] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b010};
    logic [31:0] t_rd   [6] = '{32'h80112233, 32'h80112233, 32'h7FFF0000, 32'h12348001, 32'h8001ABCD, 32'hDEADBEEF};
    logic [31:0] t_exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007FFF, 32'hFFFF8001, 32'h00008001, 32'hDEADBEEF};
    for (int i = 0; i < 6; i++) begin
      core_addr = t_addr[i]; core_byte_en = t_sz[i]; core_ren = 1;
      @(negedge brq_clk);
      n_total++; if ({mem_req, mem_we, mem_wstrb} !== 6'b100000) $display("FAIL ld%0d_req act=%b exp=100000", i, {mem_req, mem_we, mem_wstrb}); else n_pass++;
      n_total++; if (mem_addr !== t_addr[i][14:2]) $display("FAIL ld%0d_addr act=%h exp=%h", i, mem_addr, t_addr[i][14:2]); else n_pass++;
      mem_ack = 1; mem_rdata = t_rd[i];
      @(negedge brq_clk);
      mem_ack = 0; mem_rdata = 32'h0;
      n_total++; if (core_rdata !== t_exp[i]) $display("FAIL ld%0d_data act=%h exp=%h", i, core_rdata, t_exp[i]); else n_pass++;
      n_total++; if ({core_stall, mem_req} !== 2'b00) $display("FAIL ld%0d_done act=%b exp=00", i, {core_stall, mem_req}); else n_pass++;
      core_ren = 0;
      @(negedge brq_clk);
    end
  endtask

  task automatic test_timeout();
    int cycles = 0;
    core_addr = 15'h0004; core_wdata = 32'h11223344; core_byte_en = 3'b010; core_wen = 1;
    @(negedge brq_clk);
    core_wen = 0;
    n_total++; if (mem_wstrb !== 4'b1111) $display("FAIL to_wstrb act=%b exp=1111", mem_wstrb); else n_pass++;
    while (mem_req && cycles < 40) begin
      cycles++;
      @(negedge brq_clk);
    end
    n_total++; if (cycles !== 16) $display("FAIL to_req_cycles act=%0d exp=16", cycles); else n_pass++;
    n_total++; if ({core_bus_err, core_stall, mem_req} !== 3'b100) $display("FAIL to_done act=%b exp=100", {core_bus_err, core_stall, mem_req}); else n_pass++;
    n_total++; if (core_rdata !== 32'h0) $display("FAIL to_rdata act=%h exp=0", core_rdata); else n_pass++;
    @(negedge brq_clk);
    n_total++; if (core_bus_err !== 1'b0) $display("FAIL to_pulse act=%b exp=0", core_bus_err); else n_pass++;
  endtask

  task automatic test_stray_ack();
    mem_ack = 1; mem_rdata = 32'hCAFEBABE;
    @(negedge brq_clk);
    mem_ack = 0;
    n_total++; if ({core_rdata, core_stall, mem_req} !== 34'd0) $display("FAIL stray_ack act=%h exp=0", {core_rdata, core_stall, mem_req}); else n_pass++;
  endtask

  task automatic test_misalign();
    core_addr = 15'h0002; core_byte_en = 3'b010; core_ren = 1;
    #1;
    n_total++; if ({core_stall, mem_req} !== 2'b00) $display("FAIL mis_stall act=%b exp=00", {core_stall, mem_req}); else n_pass++;
    @(negedge brq_clk);
    core_ren = 0;
    n_total++; if ({core_misalign, mem_req, core_stall} !== 3'b100) $display("FAIL mis_pulse act=%b exp=100", {core_misalign, mem_req, core_stall}); else n_pass++;
    @(negedge brq_clk);
    n_total++; if ({core_misalign, mem_req} !== 2'b00) $display("FAIL mis_clear act=%b exp=00", {core_misalign, mem_req}); else n_pass++;
    core_addr = 15'h0000; core_byte_en = 3'b011; core_wen = 1;
    @(negedge brq_clk);
    core_wen = 0;
    n_total++; if ({core_misalign, mem_req} !== 2'b10) $display("FAIL bad_code act=%b exp=10", {core_misalign, mem_req}); else n_pass++;
    @(negedge brq_clk);
  endtask

  task automatic test_reset_mid();
    core_addr = 15'h0008; core_byte_en = 3'b010; core_ren = 1;
    @(negedge brq_clk);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    @(negedge brq_clk);
    mem_ack = 0;
    @(negedge brq_clk);
    core_wen = 1; core_wdata = 32'hFFFFFFFF; core_ren = 0;
    @(negedge brq_clk);
    core_wen = 0;
    n_total++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL rm_inreq act=%b exp=11", {mem_req, mem_we}); else n_pass++;
    brq_rst = 0;
    #1;
    n_total++; if ({core_rdata, core_stall, core_bus_err, core_misalign} !== 35'd0) $display("FAIL rm_core act=%h exp=0", {core_rdata, core_stall, core_bus_err, core_misalign}); else n_pass++;
    n_total++; if ({mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr} !== 51'd0) $display("FAIL rm_mem act=%h exp=0", {mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr}); else n_pass++;
    #2 brq_rst = 1;
    @(negedge brq_clk);
    core_addr = 15'h0008; core_byte_en = 3'b010; core_ren = 1;
    @(negedge brq_clk);
    core_ren = 0;
    n_total++; if ({mem_req, mem_addr} !== {1'b1, 13'h0002}) $display("FAIL rm_lw_req act=%h exp=%h", {mem_req, mem_addr}, {1'b1, 13'h0002}); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h13579BDF;
    @(negedge brq_clk);
    mem_ack = 0;
    n_total++; if ({core_rdata, core_stall, core_bus_err} !== {32'h13579BDF, 2'b00}) $display("FAIL rm_lw_data act=%h exp=13579bdf", core_rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_timeout();
    test_stray_ack();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
